// File: rtl/stream_chk_pkg.sv
// ---------------------------------------------------------------------------
// stream_chk_pkg
// Shared types and helpers for the stream #1 receive checker.
//   chk_state_e : checker state (IDLE / RUN / HALT)
//   sat_inc     : saturating increment for counters up to SAT_MAX_W bits
// ---------------------------------------------------------------------------
package stream_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chk_state_e;

  // Widest counter sat_inc can handle; callers zero-extend into this width.
  localparam int unsigned SAT_MAX_W = 64;

  // Increment 'value' unless its low 'width' bits are already all ones.
  // Upper bits beyond 'width' are expected to be zero.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] value,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] ones;
    if (width >= SAT_MAX_W) begin
      ones = '1;
    end else begin
      ones = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    end
    if (value == ones) begin
      return value;
    end
    return value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/stream_stall_gen.sv
// ---------------------------------------------------------------------------
// stream_stall_gen
// Deterministic backpressure generator for the checker's ready output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : checker will be in RUN during the next cycle
//   clear      : restart the pattern (checker is being (re)started)
//   rdy        : registered ready, low for one cycle in every stall_period
//                RUN cycles (always high in RUN when stall_period is 0)
// ---------------------------------------------------------------------------
module stream_stall_gen #(
  parameter int unsigned stall_period = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic rdy
);

  localparam int unsigned CW   = (stall_period > 1) ? $clog2(stall_period) : 1;
  localparam int unsigned LAST = (stall_period > 0) ? stall_period - 1 : 0;

  logic [CW-1:0] cnt;
  logic          at_last;
  logic          stall_next;

  // With stall_period 0 the counter sits at 0 and never produces a stall.
  assign at_last    = (cnt == CW'(LAST));
  assign stall_next = (stall_period != 0) && at_last;

  // The counter advances on every RUN cycle regardless of producer activity;
  // ready drops in the cycle that follows the counter's last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rdy <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      rdy <= enable;
    end else if (enable) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
      rdy <= !stall_next;
    end else begin
      rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_rx_checker.sv
// ---------------------------------------------------------------------------
// stream_rx_checker
// Self-checking sink for the firmware's stream #1 output. Applies a
// deterministic backpressure pattern, compares every accepted beat against an
// arithmetic sequence (init + k*step, wrapping) and keeps saturating beat /
// error counters plus a capture of the first mismatch.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / stop        : single-cycle control pulses (stop wins)
//   halt_on_err         : first mismatch moves the checker to HALT
//   exp_init / exp_step : expected sequence, sampled on start
//   s1o_valid/s1o_data  : producer side of the stream
//   s1o_rdy             : registered ready back to the producer
//   beat_count/err_count: accepted / mismatched beat counters
//   first_err_*         : data, expected value and index of first mismatch
//   busy / halted       : state is RUN / HALT
// cnt_bits must not exceed stream_chk_pkg::SAT_MAX_W.
// ---------------------------------------------------------------------------
module stream_rx_checker
  import stream_chk_pkg::*;
#(
  parameter int unsigned num_bits     = 127,
  parameter int unsigned cnt_bits     = 32,
  parameter int unsigned stall_period = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                halt_on_err,
  input  logic [num_bits-1:0] exp_init,
  input  logic [num_bits-1:0] exp_step,
  input  logic                s1o_valid,
  output logic                s1o_rdy,
  input  logic [num_bits-1:0] s1o_data,
  output logic [cnt_bits-1:0] beat_count,
  output logic [cnt_bits-1:0] err_count,
  output logic                first_err_vld,
  output logic [num_bits-1:0] first_err_data,
  output logic [num_bits-1:0] first_err_exp,
  output logic [cnt_bits-1:0] first_err_idx,
  output logic                busy,
  output logic                halted
);

  chk_state_e          state_q;
  chk_state_e          state_d;
  logic [num_bits-1:0] exp_q;
  logic [num_bits-1:0] step_q;
  logic                restart;
  logic                accept;
  logic                mismatch;
  logic                stall_en;

  // stop always wins, so a start coinciding with stop is ignored entirely.
  assign restart  = start && !stop;
  // A handshake in a restart cycle is discarded; one in a stop cycle counts.
  assign accept   = (state_q == ST_RUN) && s1o_valid && s1o_rdy && !restart;
  assign mismatch = accept && (s1o_data != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (restart) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)                            state_d = ST_IDLE;
        else if (restart)                    state_d = ST_RUN;
        else if (mismatch && halt_on_err)    state_d = ST_HALT;
      end
      ST_HALT: begin
        if (stop)         state_d = ST_IDLE;
        else if (restart) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered, so the stall generator is driven by the state the
  // checker is about to enter rather than the current one.
  always_comb begin
    busy     = 1'b0;
    halted   = 1'b0;
    stall_en = 1'b0;
    busy     = (state_q == ST_RUN);
    halted   = (state_q == ST_HALT);
    stall_en = (state_d == ST_RUN);
  end

  stream_stall_gen #(
    .stall_period (stall_period)
  ) u_stall (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (stall_en),
    .clear  (restart),
    .rdy    (s1o_rdy)
  );

  // Expected-value datapath, counters and first-mismatch capture. The index
  // captured is the beat count before the failing beat is added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q          <= '0;
      step_q         <= '0;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_vld  <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      first_err_idx  <= '0;
    end else if (restart) begin
      exp_q          <= exp_init;
      step_q         <= exp_step;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_vld  <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      first_err_idx  <= '0;
    end else if (accept) begin
      beat_count <= cnt_bits'(sat_inc(SAT_MAX_W'(beat_count), cnt_bits));
      exp_q      <= exp_q + step_q;
      if (mismatch) begin
        err_count <= cnt_bits'(sat_inc(SAT_MAX_W'(err_count), cnt_bits));
        if (!first_err_vld) begin
          first_err_vld  <= 1'b1;
          first_err_data <= s1o_data;
          first_err_exp  <= exp_q;
          first_err_idx  <= beat_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_stream_rx_checker
// Two checker instances (stall_period 0 and 4) share one stimulus set; 'sel'
// picks which one is started and observed. The producer pushes a predicted
// outcome per beat into a scoreboard queue; a negedge monitor pops it after
// each handshake and also tracks state and the ready pattern.
// ---------------------------------------------------------------------------
module tb_stream_rx_checker;

  localparam int NB = 127;
  localparam int CB = 32;
  localparam int P4 = 4;

  typedef struct {
    logic [CB-1:0] beats;
    logic [CB-1:0] errs;
    bit            fvld;
    logic [NB-1:0] fdata;
    logic [NB-1:0] fexp;
    logic [CB-1:0] fidx;
    bit            halts;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          halt_on_err;
  logic          s1o_valid;
  logic          sel;
  logic [NB-1:0] exp_init;
  logic [NB-1:0] exp_step;
  logic [NB-1:0] s1o_data;
  logic          start0, start4;

  logic          rdy0, rdy4, fvld0, fvld4, busy0, busy4, halted0, halted4;
  logic [CB-1:0] beat0, beat4, err0, err4, fidx0, fidx4;
  logic [NB-1:0] fdata0, fdata4, fexp0, fexp4;

  logic          sel_rdy, sel_fvld, sel_busy, sel_halted;
  logic [CB-1:0] sel_beat, sel_err, sel_fidx;
  logic [NB-1:0] sel_fdata, sel_fexp;

  int checks = 0;
  int errors = 0;

  sb_entry_t     sb_q[$];
  logic [NB-1:0] tx_q[$];

  logic [NB-1:0] m_init, m_step, m_fdata, m_fexp;
  int            m_idx, m_err, m_fidx;
  bit            m_fvld, m_hoe;

  bit mon_run = 1'b0;
  bit mon_halt = 1'b0;
  bit pend_hs = 1'b0;
  bit pend_restart = 1'b0;
  int mon_j = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start4 = start & sel;

  assign sel_rdy    = sel ? rdy4    : rdy0;
  assign sel_fvld   = sel ? fvld4   : fvld0;
  assign sel_busy   = sel ? busy4   : busy0;
  assign sel_halted = sel ? halted4 : halted0;
  assign sel_beat   = sel ? beat4   : beat0;
  assign sel_err    = sel ? err4    : err0;
  assign sel_fidx   = sel ? fidx4   : fidx0;
  assign sel_fdata  = sel ? fdata4  : fdata0;
  assign sel_fexp   = sel ? fexp4   : fexp0;

  stream_rx_checker #(.num_bits(NB), .cnt_bits(CB), .stall_period(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop),
    .halt_on_err(halt_on_err), .exp_init(exp_init), .exp_step(exp_step),
    .s1o_valid(s1o_valid), .s1o_rdy(rdy0), .s1o_data(s1o_data),
    .beat_count(beat0), .err_count(err0), .first_err_vld(fvld0),
    .first_err_data(fdata0), .first_err_exp(fexp0), .first_err_idx(fidx0),
    .busy(busy0), .halted(halted0)
  );

  stream_rx_checker #(.num_bits(NB), .cnt_bits(CB), .stall_period(P4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop),
    .halt_on_err(halt_on_err), .exp_init(exp_init), .exp_step(exp_step),
    .s1o_valid(s1o_valid), .s1o_rdy(rdy4), .s1o_data(s1o_data),
    .beat_count(beat4), .err_count(err4), .first_err_vld(fvld4),
    .first_err_data(fdata4), .first_err_exp(fexp4), .first_err_idx(fidx4),
    .busy(busy4), .halted(halted4)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: the k-th accepted beat should equal init + k*step mod 2^127.
  task automatic modelBeat(input logic [NB-1:0] v, output sb_entry_t e);
    logic [NB-1:0] expv;
    expv = m_init + m_step * NB'(m_idx);
    e.halts = 1'b0;
    if (v !== expv) begin
      if (!m_fvld) begin
        m_fvld  = 1'b1;
        m_fdata = v;
        m_fexp  = expv;
        m_fidx  = m_idx;
      end
      m_err++;
      e.halts = m_hoe;
    end
    m_idx++;
    e.beats = CB'(m_idx);
    e.errs  = CB'(m_err);
    e.fvld  = m_fvld;
    e.fdata = m_fdata;
    e.fexp  = m_fexp;
    e.fidx  = CB'(m_fidx);
  endtask

  task automatic pulseStart(input logic [NB-1:0] init, input logic [NB-1:0] step, input bit hoe);
    exp_init    = init;
    exp_step    = step;
    halt_on_err = hoe;
    start       = 1'b1;
    m_init = init; m_step = step; m_hoe = hoe;
    m_idx = 0; m_err = 0; m_fidx = 0; m_fvld = 1'b0; m_fdata = '0; m_fexp = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_init = {$urandom, $urandom, $urandom, $urandom};
    exp_step = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic loadRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) tx_q.push_back(NB'(i));
  endtask

  // Producer: presents tx_q in order, holding each value until accepted.
  // gap_pct inserts idle cycles; scramble lets valid/data wander while rdy is low.
  task automatic applyStimulus(input int gap_pct, input bit scramble);
    logic [NB-1:0] v;
    sb_entry_t     e;
    int            waited;
    bit            took;
    while (tx_q.size() > 0) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s1o_valid = 1'b0;
        s1o_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
      end else begin
        v = tx_q.pop_front();
        modelBeat(v, e);
        sb_q.push_back(e);
        took = 1'b0;
        waited = 0;
        while (!took && waited < 50) begin
          s1o_valid = 1'b1;
          s1o_data  = v;
          @(negedge clk);
          took = sel_rdy && sel_busy;
          if (!took && scramble) begin
            #1;
            s1o_valid = 1'($urandom_range(1));
            s1o_data  = {$urandom, $urandom, $urandom, $urandom};
          end
          @(posedge clk);
          #1;
          waited++;
        end
        checkOutput("beat_accepted", took, 1);
        if (!took || e.halts) break;
      end
    end
    s1o_valid = 1'b0;
    tx_q.delete();
  endtask

  // Monitor: after each handshake edge pops the scoreboard; every cycle checks
  // busy/halted and the ready pattern, then predicts the next edge.
  always @(negedge clk) begin : mon_blk
    sb_entry_t e;
    bit        exp_rdy;
    bit        restart_now;
    bit        hs_now;
    int        period;
    if (!rst_n) begin
      mon_run = 1'b0; mon_halt = 1'b0; pend_hs = 1'b0; pend_restart = 1'b0; mon_j = 0;
      sb_q.delete();
    end else begin
      if (pend_hs) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_beat", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_beat_count", sel_beat, e.beats);
          checkOutput("sb_err_count", sel_err, e.errs);
          checkOutput("sb_first_err_vld", sel_fvld, e.fvld);
          if (e.fvld) begin
            checkOutput("sb_first_err_data", sel_fdata, e.fdata);
            checkOutput("sb_first_err_exp", sel_fexp, e.fexp);
            checkOutput("sb_first_err_idx", sel_fidx, e.fidx);
          end
        end
      end
      if (pend_restart) begin
        checkOutput("restart_beat_clear", sel_beat, 0);
        checkOutput("restart_err_clear", sel_err, 0);
        checkOutput("restart_fvld_clear", sel_fvld, 0);
      end
      checkOutput("busy", sel_busy, mon_run);
      checkOutput("halted", sel_halted, mon_halt);
      period  = sel ? P4 : 0;
      exp_rdy = mon_run && !(period != 0 && mon_j > 0 && (mon_j % period) == 0);
      checkOutput("s1o_rdy", sel_rdy, exp_rdy);
      restart_now = start && !stop;
      hs_now      = exp_rdy && s1o_valid && !restart_now;
      if (stop) begin
        mon_run = 1'b0; mon_halt = 1'b0;
      end else if (restart_now) begin
        mon_run = 1'b1; mon_halt = 1'b0; mon_j = 0;
      end else if (hs_now && sb_q.size() > 0 && sb_q[0].halts) begin
        mon_run = 1'b0; mon_halt = 1'b1;
      end else if (mon_run) begin
        mon_j++;
      end
      pend_hs      = hs_now;
      pend_restart = restart_now;
    end
  end

  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NB-1:0]  top_val;
    logic [127:0]   rnd;
    logic [NB-1:0]  r_init, r_step, v;
    bit             r_hoe;
    int             n;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; halt_on_err = 1'b0;
    s1o_valid = 1'b0; s1o_data = '0; exp_init = '0; exp_step = '0; sel = 1'b0;

    $display("[TB] reset state");
    waitCycles(3);
    checkOutput("rst_rdy0", rdy0, 0);
    checkOutput("rst_rdy4", rdy4, 0);
    checkOutput("rst_beat", sel_beat, 0);
    checkOutput("rst_err", sel_err, 0);
    checkOutput("rst_fvld", sel_fvld, 0);
    checkOutput("rst_busy", sel_busy, 0);
    checkOutput("rst_halted", sel_halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] no stall, 0..99");
    pulseStart('0, NB'(1), 1'b0);
    checkOutput("rdy_first_cycle", sel_rdy, 1);
    loadRange(0, 99);
    applyStimulus(0, 1'b0);
    waitCycles(2);
    checkOutput("t1_beat", sel_beat, 100);
    checkOutput("t1_err", sel_err, 0);
    checkOutput("t1_fvld", sel_fvld, 0);
    pulseStop();
    waitCycles(2);

    $display("[TB] stall period 4, 0..19");
    sel = 1'b1;
    pulseStart('0, NB'(1), 1'b0);
    loadRange(0, 19);
    applyStimulus(0, 1'b0);
    waitCycles(2);
    checkOutput("t2_beat", sel_beat, 20);
    checkOutput("t2_err", sel_err, 0);
    pulseStop();
    waitCycles(2);

    $display("[TB] single mismatch, no halt");
    sel = 1'b0;
    pulseStart('0, NB'(1), 1'b0);
    tx_q = '{NB'(0), NB'(1), NB'(2), NB'(7), NB'(4), NB'(5)};
    applyStimulus(0, 1'b0);
    waitCycles(2);
    checkOutput("t3_err", sel_err, 1);
    checkOutput("t3_fdata", sel_fdata, 7);
    checkOutput("t3_fexp", sel_fexp, 3);
    checkOutput("t3_fidx", sel_fidx, 3);
    checkOutput("t3_beat", sel_beat, 6);
    pulseStop();
    waitCycles(2);

    $display("[TB] single mismatch, halt");
    sel = 1'b1;
    pulseStart('0, NB'(1), 1'b1);
    tx_q = '{NB'(0), NB'(1), NB'(2), NB'(7), NB'(4), NB'(5)};
    applyStimulus(0, 1'b0);
    s1o_valid = 1'b1;
    s1o_data  = NB'(4);
    waitCycles(3);
    checkOutput("t4_halted", sel_halted, 1);
    checkOutput("t4_rdy", sel_rdy, 0);
    checkOutput("t4_beat", sel_beat, 4);
    s1o_valid = 1'b0;
    pulseStart('0, NB'(1), 1'b1);
    checkOutput("t4_restart_busy", sel_busy, 1);
    checkOutput("t4_restart_halted", sel_halted, 0);
    checkOutput("t4_restart_beat", sel_beat, 0);
    checkOutput("t4_restart_err", sel_err, 0);
    checkOutput("t4_restart_fvld", sel_fvld, 0);
    checkOutput("t4_restart_fdata", sel_fdata, 0);
    pulseStop();
    waitCycles(2);

    $display("[TB] expected value wrap");
    sel = 1'b0;
    top_val = '1;
    pulseStart(top_val - NB'(1), NB'(1), 1'b0);
    tx_q = '{top_val - NB'(1), top_val, NB'(0), NB'(1)};
    applyStimulus(0, 1'b0);
    waitCycles(2);
    checkOutput("t5_err", sel_err, 0);
    checkOutput("t5_beat", sel_beat, 4);
    pulseStop();
    waitCycles(2);

    $display("[TB] randomized streams");
    for (int it = 0; it < 8; it++) begin
      sel = 1'((it % 2) != 0);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      r_init = rnd[NB-1:0];
      rnd = {$urandom, $urandom, $urandom, $urandom};
      r_step = (it < 4) ? NB'($urandom_range(1, 9)) : rnd[NB-1:0];
      r_hoe = 1'($urandom_range(1));
      n = $urandom_range(8, 24);
      for (int k = 0; k < n; k++) begin
        v = r_init + r_step * NB'(k);
        if ($urandom_range(9) == 0) v = v ^ (NB'(1) << $urandom_range(NB - 1));
        tx_q.push_back(v);
      end
      pulseStart(r_init, r_step, r_hoe);
      applyStimulus(25, 1'b1);
      waitCycles(3);
      checkOutput("rand_beat", sel_beat, m_idx);
      checkOutput("rand_err", sel_err, m_err);
      checkOutput("rand_halted", sel_halted, r_hoe && (m_err > 0));
      pulseStop();
      waitCycles(2);
    end

    $display("[TB] reset mid-stream");
    sel = 1'b0;
    pulseStart('0, NB'(1), 1'b0);
    loadRange(0, 9);
    applyStimulus(0, 1'b0);
    s1o_valid = 1'b1;
    s1o_data  = NB'(10);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_beat", sel_beat, 0);
    checkOutput("mrst_err", sel_err, 0);
    checkOutput("mrst_fvld", sel_fvld, 0);
    checkOutput("mrst_fdata", sel_fdata, 0);
    checkOutput("mrst_fexp", sel_fexp, 0);
    checkOutput("mrst_fidx", sel_fidx, 0);
    checkOutput("mrst_busy", sel_busy, 0);
    checkOutput("mrst_halted", sel_halted, 0);
    checkOutput("mrst_rdy", sel_rdy, 0);
    waitCycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s1o_data = NB'(11 + i);
      waitCycles(1);
    end
    checkOutput("post_rst_beat", sel_beat, 0);
    checkOutput("post_rst_rdy", sel_rdy, 0);
    checkOutput("post_rst_busy", sel_busy, 0);
    s1o_valid = 1'b0;
    waitCycles(2);

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rx_checker.md
# stream_rx_checker

Consumer-side counterpart to the counter stimulus that drives stream #1 into the `inter` firmware. It terminates the firmware's stream #1 output (`s1o_*`), applies a deterministic backpressure pattern on `s1o_rdy`, and checks each accepted beat against an expected arithmetic sequence. It maintains beat and error counters and captures the first mismatch, so a bench or top-level harness gets a self-checking sink instead of a free-running capture register.

## Interface
- `num_bits`, 127: stream data width.
- `cnt_bits`, 32: width of the beat and error counters.
- `stall_period`, 0: backpressure period. Value 0 means `s1o_rdy` is always high in RUN. Value N>0 means `s1o_rdy` is low for one cycle in every N cycles of RUN.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle pulse; loads the expected sequence and enters RUN.
- `stop`, in, 1: single-cycle pulse; returns to IDLE. Counters are kept.
- `halt_on_err`, in, 1: when 1, the first mismatch moves the block to HALT.
- `exp_init`, in, `num_bits`: first expected value, sampled on `start`.
- `exp_step`, in, `num_bits`: increment per accepted beat, sampled on `start`.
- `s1o_valid`, in, 1: firmware output valid.
- `s1o_rdy`, out, 1: checker ready (registered).
- `s1o_data`, in, `num_bits`: firmware output data.
- `beat_count`, out, `cnt_bits`: number of accepted beats.
- `err_count`, out, `cnt_bits`: number of mismatched beats.
- `first_err_vld`, out, 1: a mismatch has been captured.
- `first_err_data`, out, `num_bits`: data of the first mismatch.
- `first_err_exp`, out, `num_bits`: expected value at the first mismatch.
- `first_err_idx`, out, `cnt_bits`: `beat_count` value at the first mismatch.
- `busy`, out, 1: state is RUN.
- `halted`, out, 1: state is HALT.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → IDLE on `stop`.
  - RUN → HALT on a mismatch when `halt_on_err`=1.
  - HALT → IDLE on `stop`.
  - HALT → RUN on `start`.
  - `stop` has priority over `start` when both are high in the same cycle.
- On `start`:
  - expected ← `exp_init`; step register ← `exp_step`.
  - `beat_count`, `err_count`, `first_err_*` and the stall counter are cleared.
- Accept: a beat is accepted when `s1o_valid && s1o_rdy` is high at a rising edge while in RUN. Each accepted beat causes:
  - `beat_count`+1.
  - expected ← expected + step, modulo 2^`num_bits`, so the sequence wraps silently.
  - If `s1o_data` != expected: `err_count`+1. If `first_err_vld`=0, capture data, expected value and index, and set `first_err_vld`.
- Counters saturate at all-ones and never wrap.
- `s1o_rdy` is 0 in IDLE and HALT. In RUN it follows the stall pattern.
- Stall pattern:
  - The stall counter runs 0..`stall_period`-1 on every RUN cycle, whether or not `s1o_valid` is high.
  - `s1o_rdy` is low in the cycle after the counter equals `stall_period`-1.
- Beats presented while `s1o_rdy`=0 are not accepted and not checked.
- `s1o_data` is ignored when `s1o_valid`=0.
- The checker must tolerate the producer dropping valid or changing data while `s1o_rdy` is low. It checks only accepted beats.

## Timing
- Reset (async assert, sync deassert by the surrounding design) sets:
  - state = IDLE.
  - `s1o_rdy`=0.
  - all counters = 0, `first_err_*` = 0, `busy`=0, `halted`=0.
- `s1o_rdy` first rises in the cycle after the `start` edge (registered, 1-cycle latency).
- Counters and `first_err_*` update at the accepting edge and are visible the following cycle. There is no extra pipeline stage.
- Mismatch with `halt_on_err`=1:
  - state = HALT and `s1o_rdy`=0 from the next cycle.
  - A beat already accepted in the same edge is counted.
- `stop` in the same cycle as a handshake: the beat is accepted and checked, then the block enters IDLE.
- `start` while in RUN restarts: counters clear and the sequence reloads. A handshake in that cycle is discarded.
- Reset mid-run aborts immediately. No beat is counted on the reset edge.

## Structure
- Package `stream_chk_pkg` holds:
  - the state enum (IDLE, RUN, HALT);
  - a saturating-increment function parameterised by width.
- Sub-module `stream_stall_gen`:
  - owns the stall counter;
  - inputs: `clk`, `rst_n`, `enable`, `clear`;
  - output: registered `rdy`.
- The top level holds the FSM, expected-value datapath, compare and capture registers.

## Test plan
- Reset, then `start` with `exp_init`=0, `exp_step`=1, `stall_period`=0; producer sends 0..99 with valid always high → `beat_count`=100, `err_count`=0, `first_err_vld`=0, `s1o_rdy` high from cycle 1 after `start`.
- `stall_period`=4, producer sends 0..19 with valid always high → `s1o_rdy` low every 4th RUN cycle; `beat_count`=20, `err_count`=0, and no value is skipped or duplicated.
- Producer sends 0,1,2,7,4,5 with `halt_on_err`=0 → `err_count`=1, `first_err_data`=7, `first_err_exp`=3, `first_err_idx`=3, `beat_count`=6.
- Same stream with `halt_on_err`=1 → `halted`=1 after the beat with value 7, `s1o_rdy`=0, `beat_count`=4; a following `start` clears everything and reaches RUN.
- `exp_init`=2^127−2, `exp_step`=1, producer sends 2^127−2, 2^127−1, 0, 1 → `err_count`=0 (expected value wraps).
- Assert `rst_n` low mid-stream after 10 beats → all outputs 0 and state IDLE within the same cycle; valid beats after reset release are ignored until `start`.
